wb_ram_arbiter: RTL and testbench



---
 rtl/wb_arb_pkg.sv | 7 +
 rtl/wb_ram_arbiter_if.sv | 27 ++
 rtl/wb_arb_picker.sv | 35 +++
 rtl/wb_ram_arbiter.sv | 112 +++++++++++
 tb/tb_wb_ram_arbiter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: arbiter state encoding and Wishbone bus widths
package wb_arb_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, ABORT} arb_state_t;
    localparam int WB_ADDR_W = 32;
    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W = 4;
endpackage

// File: rtl/wb_ram_arbiter_if.sv
// wb_ram_arbiter_if: master-side Wishbone ports plus the shared RAM slave port
interface wb_ram_arbiter_if #(parameter int N_MASTERS = 3);
    import wb_arb_pkg::*;
    logic [N_MASTERS-1:0] m_CYC_I, m_STB_I, m_WE_I, m_LOCK_I;
    logic [WB_SEL_W*N_MASTERS-1:0] m_SEL_I;
    logic [WB_ADDR_W*N_MASTERS-1:0] m_ADR_I;
    logic [WB_DATA_W*N_MASTERS-1:0] m_DAT_I;
    logic [WB_DATA_W-1:0] m_DAT_O;
    logic [N_MASTERS-1:0] m_ACK_O, m_ERR_O, m_RTY_O;
    logic s_CYC_O, s_STB_O, s_WE_O, s_LOCK_O;
    logic [WB_SEL_W-1:0] s_SEL_O;
    logic [WB_ADDR_W-1:0] s_ADR_O;
    logic [WB_DATA_W-1:0] s_DAT_O, s_DAT_I;
    logic s_ACK_I, s_ERR_I, s_RTY_I;
    modport slave (
        input  m_CYC_I, m_STB_I, m_WE_I, m_LOCK_I, m_SEL_I, m_ADR_I, m_DAT_I,
        input  s_DAT_I, s_ACK_I, s_ERR_I, s_RTY_I,
        output m_DAT_O, m_ACK_O, m_ERR_O, m_RTY_O,
        output s_CYC_O, s_STB_O, s_WE_O, s_LOCK_O, s_SEL_O, s_ADR_O, s_DAT_O
    );
    modport master (
        output m_CYC_I, m_STB_I, m_WE_I, m_LOCK_I, m_SEL_I, m_ADR_I, m_DAT_I,
        output s_DAT_I, s_ACK_I, s_ERR_I, s_RTY_I,
        input  m_DAT_O, m_ACK_O, m_ERR_O, m_RTY_O,
        input  s_CYC_O, s_STB_O, s_WE_O, s_LOCK_O, s_SEL_O, s_ADR_O, s_DAT_O
    );
endinterface

// File: rtl/wb_arb_picker.sv
// wb_arb_picker: one-hot winner, master 0 first unless starving others, then round-robin from rr_ptr
module wb_arb_picker #(
    parameter int N_MASTERS = 3,
    parameter int IW = $clog2(N_MASTERS)
) (
    input  logic [N_MASTERS-1:0] req,
    input  logic [IW-1:0]        rr_ptr,
    input  logic                 starve,
    output logic [N_MASTERS-1:0] win,
    output logic [IW-1:0]        win_idx
);
    logic found;
    always_comb begin
        win = '0;
        win_idx = '0;
        found = 1'b0;
        if (req[0] && !(starve && |req[N_MASTERS-1:1])) begin
            win[0] = 1'b1;
            found = 1'b1;
        end
        // two passes give the wrap-around search rr_ptr..N-1, then 1..rr_ptr-1
        for (int i = 1; i < N_MASTERS; i++)
            if (!found && req[i] && i >= int'(rr_ptr)) begin
                win[i] = 1'b1;
                win_idx = IW'(i);
                found = 1'b1;
            end
        for (int i = 1; i < N_MASTERS; i++)
            if (!found && req[i] && i < int'(rr_ptr)) begin
                win[i] = 1'b1;
                win_idx = IW'(i);
                found = 1'b1;
            end
    end
endmodule

// File: rtl/wb_ram_arbiter.sv
// wb_ram_arbiter: shares the RAM slave port between Wishbone masters with a priority port and a watchdog
module wb_ram_arbiter
    import wb_arb_pkg::*;
#(
    parameter int N_MASTERS = 3,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 p_clk,
    input  logic                 p_resetn,
    wb_ram_arbiter_if.slave      bus,
    output logic [N_MASTERS-1:0] grant,
    output logic [15:0]          timeout_count
);
    localparam int IW = $clog2(N_MASTERS);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    arb_state_t state, state_n;
    logic [N_MASTERS-1:0] grant_n, win;
    logic [IW-1:0] rr_ptr, rr_n, win_idx;
    logic [SW-1:0] starve_cnt, starve_n;
    logic [15:0] wd_cnt, wd_n, tc_n;
    logic own_cyc, own_stb, own_we, own_lock, term, others;
    logic [WB_SEL_W-1:0] own_sel;
    logic [WB_ADDR_W-1:0] own_adr;
    logic [WB_DATA_W-1:0] own_dat;
    assign others = |bus.m_CYC_I[N_MASTERS-1:1];
    assign term = bus.s_ACK_I | bus.s_ERR_I | bus.s_RTY_I;
    wb_arb_picker #(.N_MASTERS(N_MASTERS), .IW(IW)) u_picker (
        .req(bus.m_CYC_I),
        .rr_ptr(rr_ptr),
        .starve(starve_cnt == SW'(STARVE_LIMIT)),
        .win(win),
        .win_idx(win_idx)
    );
    // grant is one-hot or zero, so an AND-OR select yields all zeros when idle or in reset
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we = 1'b0;
        own_lock = 1'b0;
        own_sel = '0;
        own_adr = '0;
        own_dat = '0;
        for (int i = 0; i < N_MASTERS; i++)
            if (grant[i]) begin
                own_cyc = bus.m_CYC_I[i];
                own_stb = bus.m_STB_I[i];
                own_we = bus.m_WE_I[i];
                own_lock = bus.m_LOCK_I[i];
                own_sel = bus.m_SEL_I[WB_SEL_W*i +: WB_SEL_W];
                own_adr = bus.m_ADR_I[WB_ADDR_W*i +: WB_ADDR_W];
                own_dat = bus.m_DAT_I[WB_DATA_W*i +: WB_DATA_W];
            end
    end
    assign bus.s_CYC_O = (state == BUSY) && own_cyc;
    assign bus.s_STB_O = (state == BUSY) && own_stb;
    assign bus.s_WE_O = own_we;
    assign bus.s_LOCK_O = own_lock;
    assign bus.s_SEL_O = own_sel;
    assign bus.s_ADR_O = own_adr;
    assign bus.s_DAT_O = own_dat;
    assign bus.m_DAT_O = bus.s_DAT_I;
    assign bus.m_ACK_O = (state == BUSY && bus.s_ACK_I) ? grant : '0;
    assign bus.m_RTY_O = (state == BUSY && bus.s_RTY_I) ? grant : '0;
    assign bus.m_ERR_O = (state == ABORT || (state == BUSY && bus.s_ERR_I)) ? grant : '0;
    always_comb begin
        state_n = state;
        grant_n = grant;
        rr_n = rr_ptr;
        starve_n = starve_cnt;
        wd_n = '0;
        tc_n = timeout_count;
        case (state)
            IDLE: if (|bus.m_CYC_I) begin
                state_n = BUSY;
                grant_n = win;
                starve_n = !win[0] ? '0 :
                           (others && starve_cnt != SW'(STARVE_LIMIT)) ? starve_cnt + 1'b1 : starve_cnt;
                rr_n = win[0] ? rr_ptr : (win_idx == IW'(N_MASTERS - 1)) ? IW'(1) : win_idx + 1'b1;
            end
            BUSY: if (!own_cyc && !own_lock) begin
                state_n = IDLE;
                grant_n = '0;
            end else if (own_stb && !term) begin
                wd_n = wd_cnt + 1'b1;
                if (wd_n == 16'(TIMEOUT)) state_n = ABORT;
            end
            ABORT: begin
                tc_n = (timeout_count == '1) ? timeout_count : timeout_count + 1'b1;
                state_n = own_cyc ? BUSY : IDLE;
                grant_n = own_cyc ? grant : '0;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge p_clk or negedge p_resetn)
        if (!p_resetn) begin
            state <= IDLE;
            grant <= '0;
            rr_ptr <= IW'(1);
            starve_cnt <= '0;
            wd_cnt <= '0;
            timeout_count <= '0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            rr_ptr <= rr_n;
            starve_cnt <= starve_n;
            wd_cnt <= wd_n;
            timeout_count <= tc_n;
        end
endmodule

// File: tb/tb_wb_ram_arbiter.sv
// tb_wb_ram_arbiter: directed scenarios with a grant/termination scoreboard checked by a monitor
module tb_wb_ram_arbiter;
    localparam int N = 3;
    typedef struct packed {logic [N-1:0] g; logic [31:0] adr;} gexp_t;
    logic p_clk = 1'b0;
    logic p_resetn = 1'b0;
    logic [N-1:0] grant;
    logic [15:0] timeout_count;
    int vectors = 0;
    int errors = 0;
    int jobs [N] = '{0, 0, 0};
    logic slave_en = 1'b1;
    int slave_delay = 1;
    int wcnt = 0;
    logic [N-1:0] ack_s, err_s, prev_g;
    logic stb_s;
    gexp_t gq[$];
    logic [3*N-1:0] tq[$];
    gexp_t ge;
    logic [3*N-1:0] te;
    logic [31:0] adr_tab [N] = '{32'h0000_1000, 32'h0000_2040, 32'h0000_30F0};
    int z, wc;
    logic seen;

    wb_ram_arbiter_if #(.N_MASTERS(N)) bus ();
    wb_ram_arbiter #(.N_MASTERS(N), .STARVE_LIMIT(4), .TIMEOUT(255)) dut (
        .p_clk(p_clk),
        .p_resetn(p_resetn),
        .bus(bus),
        .grant(grant),
        .timeout_count(timeout_count)
    );
    always #5 p_clk = ~p_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_ack(input logic [N-1:0] g, input int idx);
        gq.push_back({g, adr_tab[idx]});
        tq.push_back({{2*N{1'b0}}, g});
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((jobs[0] + jobs[1] + jobs[2] != 0 || grant != '0) && n < limit) begin
            @(negedge p_clk);
            n++;
        end
        if (n >= limit) begin
            vectors++;
            errors++;
            $display("FAIL wait_idle: bound of %0d cycles expired, grant %b", limit, grant);
        end
    endtask

    // master and slave models: masters hold CYC/STB until terminated, slave acks after slave_delay wait cycles
    initial forever begin
        @(negedge p_clk);
        ack_s = bus.m_ACK_O;
        err_s = bus.m_ERR_O;
        stb_s = bus.s_CYC_O & bus.s_STB_O;
        @(posedge p_clk);
        #1;
        for (int i = 0; i < N; i++)
            if (bus.m_CYC_I[i] && (ack_s[i] || err_s[i])) begin
                jobs[i]--;
                bus.m_CYC_I[i] = 1'b0;
                bus.m_STB_I[i] = 1'b0;
            end else if (!bus.m_CYC_I[i] && jobs[i] > 0) begin
                bus.m_CYC_I[i] = 1'b1;
                bus.m_STB_I[i] = 1'b1;
            end
        #1;
        wcnt = (bus.s_ACK_I || !stb_s) ? 0 : wcnt + 1;
        bus.s_ACK_I = slave_en && !bus.s_ACK_I && bus.s_CYC_O && bus.s_STB_O && wcnt == slave_delay;
    end

    initial begin
        prev_g = '0;
        forever begin
            @(negedge p_clk);
            if (grant != '0 && prev_g == '0) begin
                if (gq.size() == 0) chk("unexpected_grant", grant, '0);
                else begin
                    ge = gq.pop_front();
                    chk("grant", grant, ge.g);
                    chk("s_ADR_O", bus.s_ADR_O, ge.adr);
                end
            end
            prev_g = grant;
            if (|{bus.m_RTY_O, bus.m_ERR_O, bus.m_ACK_O}) begin
                if (tq.size() == 0) chk("unexpected_term", {bus.m_RTY_O, bus.m_ERR_O, bus.m_ACK_O}, '0);
                else begin
                    te = tq.pop_front();
                    chk("rty_err_ack", {bus.m_RTY_O, bus.m_ERR_O, bus.m_ACK_O}, te);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        bus.m_CYC_I = '0;
        bus.m_STB_I = '0;
        bus.m_WE_I = 3'b100;
        bus.m_LOCK_I = '0;
        bus.m_SEL_I = '1;
        bus.m_ADR_I = {adr_tab[2], adr_tab[1], adr_tab[0]};
        bus.m_DAT_I = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        bus.s_DAT_I = '0;
        bus.s_ACK_I = 1'b0;
        bus.s_ERR_I = 1'b0;
        bus.s_RTY_I = 1'b0;
        repeat (3) @(negedge p_clk);
        chk("rst_grant", grant, '0);
        chk("rst_s_CYC_O", bus.s_CYC_O, 1'b0);
        chk("rst_s_STB_O", bus.s_STB_O, 1'b0);
        chk("rst_s_ADR_O", bus.s_ADR_O, '0);
        chk("rst_s_DAT_O", bus.s_DAT_O, '0);
        chk("rst_timeout_count", timeout_count, '0);
        chk("rst_terms", {bus.m_RTY_O, bus.m_ERR_O, bus.m_ACK_O}, '0);
        bus.s_DAT_I = 32'hDEAD_BEEF;
        #1 chk("m_DAT_O", bus.m_DAT_O, 32'hDEAD_BEEF);
        p_resetn = 1'b1;
        // single master: one-cycle arbitration, ack on the 2nd strobe cycle, release one cycle after CYC drops
        @(negedge p_clk);
        exp_ack(3'b010, 1);
        jobs[1] = 1;
        @(negedge p_clk);
        chk("t1_grant_pre", grant, '0);
        @(negedge p_clk);
        chk("t1_s_CYC_O", bus.s_CYC_O, 1'b1);
        chk("t1_s_DAT_O", bus.s_DAT_O, 32'hBBBB_0001);
        repeat (3) @(negedge p_clk);
        chk("t1_release", grant, '0);
        wait_idle(50);
        // priority with one idle cycle between owners
        exp_ack(3'b001, 0);
        exp_ack(3'b100, 2);
        jobs[0] = 1;
        jobs[2] = 1;
        z = 0;
        seen = 1'b0;
        for (int n = 0; n < 100 && grant != 3'b100; n++) begin
            @(negedge p_clk);
            if (grant == '0 && seen) z++;
            if (grant == 3'b001) seen = 1'b1;
        end
        chk("t2_idle_gap", z, 1);
        wait_idle(100);
        // starvation guard: master 1 wins the 5th arbitration
        for (int k = 0; k < 4; k++) exp_ack(3'b001, 0);
        exp_ack(3'b010, 1);
        exp_ack(3'b001, 0);
        jobs[0] = 5;
        jobs[1] = 1;
        wait_idle(300);
        // round-robin, rr_ptr points at master 2 after the last master-1 grant
        for (int k = 0; k < 3; k++) begin
            exp_ack(3'b100, 2);
            exp_ack(3'b010, 1);
        end
        jobs[1] = 3;
        jobs[2] = 3;
        wait_idle(300);
        // watchdog abort after 255 unanswered strobe cycles
        slave_en = 1'b0;
        gq.push_back({3'b100, adr_tab[2]});
        tq.push_back({3'b000, 3'b100, 3'b000});
        jobs[2] = 1;
        wc = 0;
        for (int n = 0; n < 600 && bus.m_ERR_O == '0; n++) begin
            @(negedge p_clk);
            if (grant == 3'b100 && bus.m_ERR_O == '0) wc++;
        end
        chk("t5_wait_cycles", wc, 255);
        chk("t5_abort_s_CYC_O", bus.s_CYC_O, 1'b0);
        chk("t5_abort_s_STB_O", bus.s_STB_O, 1'b0);
        wait_idle(20);
        chk("t5_timeout_count", timeout_count, 16'd1);
        slave_en = 1'b1;
        // ack on the 255th strobe cycle beats the watchdog
        slave_delay = 254;
        exp_ack(3'b010, 1);
        jobs[1] = 1;
        wait_idle(400);
        chk("t6_timeout_count", timeout_count, 16'd1);
        slave_delay = 1;
        // locked owner keeps the bus after dropping CYC, then reset mid-transfer
        bus.m_LOCK_I[0] = 1'b1;
        exp_ack(3'b001, 0);
        jobs[0] = 1;
        for (int n = 0; n < 50 && jobs[0] != 0; n++) @(negedge p_clk);
        jobs[1] = 1;
        repeat (4) @(negedge p_clk);
        chk("t7_lock_hold", grant, 3'b001);
        chk("t7_lock_s_CYC_O", bus.s_CYC_O, 1'b0);
        slave_en = 1'b0;
        jobs[0] = 1;
        repeat (2) @(negedge p_clk);
        chk("t7_busy_s_CYC_O", bus.s_CYC_O, 1'b1);
        #2 p_resetn = 1'b0;
        #1;
        chk("t7_rst_grant", grant, '0);
        chk("t7_rst_s_CYC_O", bus.s_CYC_O, 1'b0);
        chk("t7_rst_s_ADR_O", bus.s_ADR_O, '0);
        chk("t7_rst_terms", {bus.m_RTY_O, bus.m_ERR_O, bus.m_ACK_O}, '0);
        chk("t7_rst_timeout_count", timeout_count, '0);
        jobs = '{0, 0, 0};
        bus.m_CYC_I = '0;
        bus.m_STB_I = '0;
        bus.m_LOCK_I = '0;
        slave_en = 1'b1;
        repeat (2) @(negedge p_clk);
        p_resetn = 1'b1;
        // rr_ptr restarts at master 1 after reset
        exp_ack(3'b010, 1);
        exp_ack(3'b100, 2);
        jobs[1] = 1;
        jobs[2] = 1;
        wait_idle(100);
        repeat (2) @(negedge p_clk);
        chk("grant_q_left", gq.size(), 0);
        chk("term_q_left", tq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
